hd63701_ram_arbiter: RTL and testbench
======================================

# hd63701_ram_arbiter

Shares the HD63701 built-in 128-byte work RAM ($0080-$00FF) between the MCU core and a host-side debug/save-state port. The MCU always has priority and is never stalled. Host accesses go through a req/ack handshake and are scheduled into cycles where the MCU is not addressing the RAM window. The block replaces the plain built-in RAM instance and provides the same `en_biram`/`biramd` interface to the data selector.

## Interface
- `TIMEOUT`, default 255: PEND cycles before a host request is aborted (1..255).
- `mcu_clx2`  in  1  MCU clock; all state updates on the rising edge.
- `mcu_rst_n`  in  1  asynchronous, active-low reset.
- `mcu_ad`  in  16  MCU address.
- `mcu_wr`  in  1  MCU write strobe, active high.
- `mcu_do`  in  8  MCU write data.
- `en_biram`  out  1  combinational decode, `mcu_ad[15:7]==9'b000000001`.
- `biramd`  out  8  registered RAM read data to the MCU.
- `host_req`  in  1  host request; hold until `host_ack`.
- `host_we`  in  1  1 = write, 0 = read; sampled with `host_req`.
- `host_addr`  in  7  RAM offset (maps to $0080+`host_addr`).
- `host_wdata`  in  8  host write data.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  8  read result; valid from `host_ack` until the next read completes.
- `host_busy`  out  1  high in PEND or DONE.
- `host_timeout`  out  1  the last request was aborted.

## Operation
- The block contains a 128x8 single-port synchronous RAM. Reset does not clear it.
- MCU cycle, `en_biram`=1:
  - If `mcu_wr`=1, write `mcu_do` to `mem[mcu_ad[6:0]]`.
  - Otherwise load `biramd` from `mem[mcu_ad[6:0]]`.
  - `biramd` holds its value in every other cycle.
- FSM states are IDLE, PEND and DONE.
- IDLE, `host_req`=1 at an edge:
  - Latch `host_we`, `host_addr` and `host_wdata`.
  - Clear `host_timeout` and the wait counter.
  - Go to PEND.
- PEND, `en_biram`=0 at an edge:
  - Perform the latched operation. A write updates `mem`; a read loads `host_rdata`.
  - Go to DONE.
- PEND, `en_biram`=1 at an edge:
  - The MCU owns the port and the wait counter increments (8 bits, saturating).
  - When the counter reaches `TIMEOUT` (only if the macro is defined): abort, set `host_timeout`, leave `mem` and `host_rdata` unchanged, go to DONE.
- DONE: `host_ack`=1. The next edge returns the FSM to IDLE. `host_req` is ignored during DONE.
- The host must drop `host_req` at the edge where it sees `host_ack`, or re-assert it later for the next transfer.
- Host and MCU never access the RAM in the same cycle. A host write followed by an MCU read of the same location returns the new data.

## Timing
- Reset values:
  - State IDLE.
  - `host_ack`, `host_busy` and `host_timeout` are 0.
  - `host_rdata` and `biramd` are 8'h00.
  - Wait counter is 0.
- Reset mid-transfer returns the FSM to IDLE with no ack. A latched write that has not yet reached its access edge is discarded.
- Best-case latency: `host_req` sampled at edge E0, RAM access at E1, `host_ack` high from E1 to E2. The next request can be sampled at E3.
- Each MCU RAM cycle in PEND adds one cycle of latency.
- `host_busy` = (state != IDLE), registered.
- MCU read latency is 1 cycle: address at edge N, `biramd` valid after edge N.

## Configuration
- `HD63701_RAMARB_TIMEOUT_EN` defined:
  - Wait counter and abort path are present.
  - `host_timeout` is set after `TIMEOUT` MCU-owned PEND cycles.
- Not defined:
  - No wait counter; PEND waits indefinitely for a free cycle.
  - `host_timeout` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Host write then read with the MCU idle (`mcu_ad`=$F000):
  - Write addr 7'h05 = 8'hA5; `host_ack` pulses 2 cycles after `host_req`.
  - Read addr 7'h05 returns `host_rdata`=8'hA5.
- Cross-side coherence:
  - MCU writes $0090 = 8'h3C; host read of addr 7'h10 returns 8'h3C.
  - Host writes addr 7'h11 = 8'h77; MCU read of $0091 gives `biramd`=8'h77.
- Contention: hold `mcu_ad` in $0080-$00FF for 10 cycles during PEND. The host access occurs on the first cycle with `en_biram`=0, `host_ack` follows, and the MCU data path is unaffected.
- Timeout (macro on, `TIMEOUT`=4): MCU stays in the RAM window. After 4 PEND cycles, `host_timeout`=1 and `host_ack` pulses with no RAM change. The next request clears `host_timeout`.
- Reset during PEND of a write to 7'h20:
  - Assert `mcu_rst_n`=0 mid-PEND; all outputs go to their reset values.
  - Location 7'h20 keeps its old value, and RAM contents are otherwise preserved across reset.
- Back-to-back: `host_req` re-asserted right after the ack. The second transfer is sampled at E3 and completes, and `host_busy` tracks both transfers.

Source files
------------

// File: rtl/hd63701_ram_arbiter.sv
// hd63701_ram_arbiter
// Shares the HD63701 128-byte built-in work RAM ($0080-$00FF) between the MCU
// core and a host-side debug/save-state port. The MCU always wins the single
// RAM port; host transfers are slotted into cycles where the MCU is outside
// the RAM window.
//
// Optional feature macro: HD63701_RAMARB_TIMEOUT_EN
//   defined   -> a saturating wait counter aborts a pending host request after
//                TIMEOUT MCU-owned cycles and raises host_timeout.
//   undefined -> a pending host request waits indefinitely; host_timeout = 0.

module hd63701_ram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        mcu_clx2,
  input  logic        mcu_rst_n,
  input  logic [15:0] mcu_ad,
  input  logic        mcu_wr,
  input  logic [7:0]  mcu_do,
  output logic        en_biram,
  output logic [7:0]  biramd,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_busy,
  output logic        host_timeout
);

  // Host transfer FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // TIMEOUT only matters for the abort path; an out-of-range value is clamped
  // there. This empty block keeps the parameter referenced in every build.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_clamped
  end

  logic [1:0] state;
  logic [1:0] state_next;

  logic       lat_we;
  logic [6:0] lat_addr;
  logic [7:0] lat_wdata;

  logic [7:0] mem [0:127];

  logic       ram_we;
  logic [6:0] ram_addr;
  logic [7:0] ram_wdata;

  logic       host_fire;
  logic       abort;

  // The MCU owns the RAM window whenever its address decodes into $0080-$00FF
  assign en_biram = (mcu_ad[15:7] == 9'b000000001);

  // A host access happens only on a PEND cycle the MCU leaves free
  assign host_fire = (state == PEND) && !en_biram;

  assign host_ack  = (state == DONE);
  assign host_busy = (state != IDLE);

`ifdef HD63701_RAMARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT =
    (TIMEOUT < 1)   ? 8'd1   :
    (TIMEOUT > 255) ? 8'd255 : 8'(TIMEOUT);

  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       timeout_flag;

  // Saturating increment of the MCU-owned PEND cycle count
  always_comb begin
    wait_next = wait_cnt;
    if (wait_cnt != 8'hFF) begin
      wait_next = wait_cnt + 8'd1;
    end
  end

  assign abort = (state == PEND) && en_biram && (wait_next >= TIMEOUT_LIMIT);

  // Wait counter and sticky timeout flag, both cleared when a request is taken
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      wait_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (state == IDLE && host_req) begin
      wait_cnt     <= 8'd0;
      timeout_flag <= 1'b0;
    end else if (state == PEND && en_biram) begin
      wait_cnt <= wait_next;
      if (abort) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign host_timeout = timeout_flag;
`else
  assign abort        = 1'b0;
  assign host_timeout = 1'b0;
`endif

  // Next-state logic for the host handshake
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (host_req) begin
          state_next = PEND;
        end
      end
      PEND: begin
        if (!en_biram || abort) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; reset drops any transfer in flight without an ack
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the host command when a request is accepted in IDLE
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= 7'd0;
      lat_wdata <= 8'd0;
    end else if (state == IDLE && host_req) begin
      lat_we    <= host_we;
      lat_addr  <= host_addr;
      lat_wdata <= host_wdata;
    end
  end

  // Single RAM port mux: MCU first, host only in a free PEND cycle
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = mcu_ad[6:0];
    ram_wdata = mcu_do;
    if (en_biram) begin
      ram_we    = mcu_wr;
      ram_addr  = mcu_ad[6:0];
      ram_wdata = mcu_do;
    end else if (host_fire) begin
      ram_we    = lat_we;
      ram_addr  = lat_addr;
      ram_wdata = lat_wdata;
    end
  end

  // RAM array write; contents deliberately survive reset
  always_ff @(posedge mcu_clx2) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // MCU read data register, holds between MCU RAM reads
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      biramd <= 8'h00;
    end else if (en_biram && !mcu_wr) begin
      biramd <= mem[ram_addr];
    end
  end

  // Host read data register, updated only by a completed host read
  always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
    if (!mcu_rst_n) begin
      host_rdata <= 8'h00;
    end else if (host_fire && !lat_we) begin
      host_rdata <= mem[ram_addr];
    end
  end

endmodule

// File: tb/tb_hd63701_ram_arbiter.sv
// tb_hd63701_ram_arbiter
// Directed self-checking bench for hd63701_ram_arbiter. When compiled with
// HD63701_RAMARB_TIMEOUT_EN the DUT is built with TIMEOUT=4 and the abort path
// is exercised; otherwise the indefinite-wait behaviour is checked.

module tb_hd63701_ram_arbiter;

`ifdef HD63701_RAMARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int HOLD       = 3;
`else
  localparam int TB_TIMEOUT = 255;
  localparam int HOLD       = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] mcu_ad;
  logic        mcu_wr;
  logic [7:0]  mcu_do;
  logic        en_biram;
  logic [7:0]  biramd;
  logic        host_req;
  logic        host_we;
  logic [6:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic        host_busy;
  logic        host_timeout;

  int checks   = 0;
  int failures = 0;
  int cycles;

  hd63701_ram_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .mcu_clx2    (clk),
    .mcu_rst_n   (rst_n),
    .mcu_ad      (mcu_ad),
    .mcu_wr      (mcu_wr),
    .mcu_do      (mcu_do),
    .en_biram    (en_biram),
    .biramd      (biramd),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_busy   (host_busy),
    .host_timeout(host_timeout)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we,
                               input logic [6:0] addr, input logic [7:0] wdata);
    host_req   = req;
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  task automatic mcuDrive(input logic [15:0] ad, input logic wr,
                          input logic [7:0] dout);
    mcu_ad = ad;
    mcu_wr = wr;
    mcu_do = dout;
  endtask

  // Full host transfer with bounded wait; drops req once ack is seen
  task automatic hostXfer(input string tag, input logic we, input logic [6:0] addr,
                          input logic [7:0] wdata, output int ncyc);
    applyStimulus(1'b1, we, addr, wdata);
    ncyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      ncyc++;
      if (host_ack) break;
    end
    checkOutput(tag, {15'd0, host_ack}, 16'd1);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    mcuDrive(16'hF000, 1'b0, 8'h00);
    step();
    step();

    // Reset values and address decode boundaries
    checkOutput("rst_ack",     {15'd0, host_ack},     16'd0);
    checkOutput("rst_busy",    {15'd0, host_busy},    16'd0);
    checkOutput("rst_timeout", {15'd0, host_timeout}, 16'd0);
    checkOutput("rst_rdata",   {8'd0, host_rdata},    16'h00);
    checkOutput("rst_biramd",  {8'd0, biramd},        16'h00);
    checkOutput("dec_F000",    {15'd0, en_biram},     16'd0);
    mcu_ad = 16'h0080; #1;
    checkOutput("dec_0080",    {15'd0, en_biram},     16'd1);
    mcu_ad = 16'h00FF; #1;
    checkOutput("dec_00FF",    {15'd0, en_biram},     16'd1);
    mcu_ad = 16'h007F; #1;
    checkOutput("dec_007F",    {15'd0, en_biram},     16'd0);
    mcu_ad = 16'h0100; #1;
    checkOutput("dec_0100",    {15'd0, en_biram},     16'd0);
    mcu_ad = 16'hF000;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Host write with MCU idle: busy in PEND, ack two cycles after req
    applyStimulus(1'b1, 1'b1, 7'h05, 8'hA5);
    step();
    checkOutput("wr_pend_busy", {15'd0, host_busy}, 16'd1);
    checkOutput("wr_pend_ack",  {15'd0, host_ack},  16'd0);
    step();
    checkOutput("wr_ack",       {15'd0, host_ack},  16'd1);
    checkOutput("wr_done_busy", {15'd0, host_busy}, 16'd1);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
    checkOutput("wr_idle_ack",  {15'd0, host_ack},  16'd0);
    checkOutput("wr_idle_busy", {15'd0, host_busy}, 16'd0);

    hostXfer("rd05_ack", 1'b0, 7'h05, 8'h00, cycles);
    checkOutput("rd05_latency", 16'(cycles), 16'd2);
    checkOutput("rd05_data", {8'd0, host_rdata}, 16'hA5);

    // MCU writes, host reads back
    mcuDrive(16'h0090, 1'b1, 8'h3C);
    step();
    mcuDrive(16'hF000, 1'b0, 8'h00);
    hostXfer("rd10_ack", 1'b0, 7'h10, 8'h00, cycles);
    checkOutput("rd10_data", {8'd0, host_rdata}, 16'h3C);

    // Host writes, MCU reads back; biramd then holds
    hostXfer("wr11_ack", 1'b1, 7'h11, 8'h77, cycles);
    mcuDrive(16'h0091, 1'b0, 8'h00);
    step();
    checkOutput("mcu_rd91", {8'd0, biramd}, 16'h77);
    mcuDrive(16'hF000, 1'b0, 8'h00);
    step();
    checkOutput("biramd_hold", {8'd0, biramd}, 16'h77);

    // Contention: MCU sits in the window while the host write is pending
    mcuDrive(16'h0090, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 7'h12, 8'h5A);
    step();
    for (int i = 0; i < HOLD; i++) begin
      step();
    end
    checkOutput("cont_ack",    {15'd0, host_ack},  16'd0);
    checkOutput("cont_busy",   {15'd0, host_busy}, 16'd1);
    checkOutput("cont_biramd", {8'd0, biramd},     16'h3C);
    checkOutput("cont_tmo",    {15'd0, host_timeout}, 16'd0);
    mcuDrive(16'hF000, 1'b0, 8'h00);
    step();
    checkOutput("cont_release_ack", {15'd0, host_ack}, 16'd1);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
    hostXfer("rd12_ack", 1'b0, 7'h12, 8'h00, cycles);
    checkOutput("rd12_data", {8'd0, host_rdata}, 16'h5A);

`ifdef HD63701_RAMARB_TIMEOUT_EN
    // Abort after TIMEOUT MCU-owned PEND cycles; RAM and rdata untouched
    mcuDrive(16'h0090, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 7'h12, 8'hFF);
    step();
    step();
    step();
    step();
    checkOutput("tmo_pre_ack", {15'd0, host_ack}, 16'd0);
    step();
    checkOutput("tmo_ack",  {15'd0, host_ack},     16'd1);
    checkOutput("tmo_flag", {15'd0, host_timeout}, 16'd1);
    checkOutput("tmo_rdata", {8'd0, host_rdata},   16'h5A);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
    mcuDrive(16'hF000, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 7'h12, 8'h00);
    step();
    checkOutput("tmo_cleared", {15'd0, host_timeout}, 16'd0);
    step();
    checkOutput("tmo_rd_ack",  {15'd0, host_ack},  16'd1);
    checkOutput("tmo_rd_data", {8'd0, host_rdata}, 16'h5A);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
`endif

    // Reset in the middle of a pending write to 7'h20
    hostXfer("wr20_ack", 1'b1, 7'h20, 8'h11, cycles);
    mcuDrive(16'h0090, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 7'h20, 8'hEE);
    step();
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack",    {15'd0, host_ack},     16'd0);
    checkOutput("mid_rst_busy",   {15'd0, host_busy},    16'd0);
    checkOutput("mid_rst_tmo",    {15'd0, host_timeout}, 16'd0);
    checkOutput("mid_rst_rdata",  {8'd0, host_rdata},    16'h00);
    checkOutput("mid_rst_biramd", {8'd0, biramd},        16'h00);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    mcuDrive(16'hF000, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_ack", {15'd0, host_ack}, 16'd0);
    hostXfer("rd20_ack", 1'b0, 7'h20, 8'h00, cycles);
    checkOutput("rd20_kept", {8'd0, host_rdata}, 16'h11);
    mcuDrive(16'h0085, 1'b0, 8'h00);
    step();
    checkOutput("mcu_rd85_kept", {8'd0, biramd}, 16'hA5);
    mcuDrive(16'hF000, 1'b0, 8'h00);

    // Back-to-back: req held through DONE, second transfer sampled at E3
    applyStimulus(1'b1, 1'b1, 7'h30, 8'hC3);
    step();
    checkOutput("b2b_e0_busy", {15'd0, host_busy}, 16'd1);
    step();
    checkOutput("b2b_e1_ack",  {15'd0, host_ack},  16'd1);
    applyStimulus(1'b1, 1'b0, 7'h30, 8'h00);
    step();
    checkOutput("b2b_e2_busy", {15'd0, host_busy}, 16'd0);
    checkOutput("b2b_e2_ack",  {15'd0, host_ack},  16'd0);
    step();
    checkOutput("b2b_e3_busy", {15'd0, host_busy}, 16'd1);
    step();
    checkOutput("b2b_e4_ack",  {15'd0, host_ack},  16'd1);
    checkOutput("b2b_rdata",   {8'd0, host_rdata}, 16'hC3);
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd0);
    step();
    checkOutput("b2b_end_busy", {15'd0, host_busy}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
